// File: rtl/spiread.sv
// spiread: read-side SPI master for the IS62WVS5128 serial SRAM.
// Sends READ + address, then streams req_len bytes back from SO.
module spiread #(
    parameter int          ADDRESSBITS = 24,
    parameter int          LENBITS     = 10,
    parameter int          CS_GAP      = 2,
    parameter logic [7:0]  OPCODE      = 8'h03
) (
    input  logic                   inverse_clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic [ADDRESSBITS-1:0] req_addr,
    input  logic [LENBITS-1:0]     req_len,
    input  logic                   so,
    output logic                   cs,
    output logic                   sck,
    output logic                   si,
    output logic [7:0]             data,
    output logic                   data_valid,
    output logic                   busy,
    output logic                   done
);
    localparam int TXW = 8 + ADDRESSBITS;
    localparam int CW  = $clog2(TXW);
    localparam int GW  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_OPC  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic               phase_q, phase_d;
    logic [CW-1:0]      bitcnt_q, bitcnt_d;
    logic [TXW-1:0]     tx_q, tx_d;
    logic [LENBITS-1:0] len_q, len_d;
    logic [6:0]         shift_q, shift_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic               cs_q, cs_d;
    logic               sck_q, sck_d;
    logic               si_q, si_d;
    logic [7:0]         data_q, data_d;
    logic               dv_q, dv_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bitcnt_d = bitcnt_q;
        tx_d     = tx_q;
        len_d    = len_q;
        shift_d  = shift_q;
        gap_d    = gap_q;
        cs_d     = cs_q;
        sck_d    = sck_q;
        si_d     = si_q;
        data_d   = data_q;
        dv_d     = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    busy_d   = 1'b1;
                    len_d    = req_len;
                    phase_d  = 1'b0;
                    bitcnt_d = '0;
                    // tx holds the bits still to send after OPCODE[7]
                    tx_d     = {OPCODE[6:0], req_addr, 1'b0};
                    if (req_len != '0) begin
                        cs_d    = 1'b0;
                        sck_d   = 1'b0;
                        si_d    = OPCODE[7];
                        state_d = S_OPC;
                    end else begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_OPC, S_ADDR, S_DATA: begin
                phase_d = ~phase_q;
                if (!phase_q) begin
                    sck_d = 1'b1;
                end else begin
                    sck_d    = 1'b0;
                    bitcnt_d = bitcnt_q + 1'b1;
                    shift_d  = {shift_q[5:0], so};
                    si_d     = tx_q[TXW-1];
                    tx_d     = tx_q << 1;
                    if (state_q == S_OPC && bitcnt_q == CW'(7)) begin
                        state_d  = S_ADDR;
                        bitcnt_d = '0;
                    end
                    if (state_q == S_ADDR &&
                        bitcnt_q == CW'(ADDRESSBITS - 1)) begin
                        state_d  = S_DATA;
                        bitcnt_d = '0;
                        si_d     = 1'b0;
                    end
                    if (state_q == S_DATA) begin
                        si_d = 1'b0;
                        if (bitcnt_q == CW'(7)) begin
                            bitcnt_d = '0;
                            data_d   = {shift_q, so};
                            dv_d     = 1'b1;
                            len_d    = len_q - 1'b1;
                            if (len_q == LENBITS'(1)) begin
                                cs_d    = 1'b1;
                                gap_d   = GW'(CS_GAP - 1);
                                state_d = S_GAP;
                            end
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge inverse_clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            phase_q  <= 1'b0;
            bitcnt_q <= '0;
            tx_q     <= '0;
            len_q    <= '0;
            shift_q  <= '0;
            gap_q    <= '0;
            cs_q     <= 1'b1;
            sck_q    <= 1'b0;
            si_q     <= 1'b0;
            data_q   <= '0;
            dv_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bitcnt_q <= bitcnt_d;
            tx_q     <= tx_d;
            len_q    <= len_d;
            shift_q  <= shift_d;
            gap_q    <= gap_d;
            cs_q     <= cs_d;
            sck_q    <= sck_d;
            si_q     <= si_d;
            data_q   <= data_d;
            dv_q     <= dv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign cs         = cs_q;
    assign sck        = sck_q;
    assign si         = si_q;
    assign data       = data_q;
    assign data_valid = dv_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: doc/spiread.md
# spiread

Read-side SPI master for the IS62WVS5128 serial SRAM used as the frame/line store. It is the counterpart of the SRAM write path. On a request it asserts CS, sends the READ opcode (0x03) and a start address, then clocks in a burst of bytes from SO. Each byte is presented to the video pipeline with a one-cycle valid strobe. The block generates its own SCK at half the `inverse_clk` rate and relies on the SRAM's sequential mode for address auto-increment.

## Interface
- `ADDRESSBITS`, 24: SRAM address width, shifted MSB first.
- `LENBITS`, 10: width of the burst-length field, in bytes.
- `CS_GAP`, 2: minimum number of `inverse_clk` cycles CS stays high after a burst, before `done` and `busy` release. Must be ≥1.
- `OPCODE`, 8'h03: SRAM READ instruction.

- `inverse_clk`  in  1  block clock; all flops use its rising edge.
- `rst`  in  1  reset: synchronous, active-high; clock `inverse_clk`.
- `req`  in  1  start-burst request; sampled only while `busy`=0.
- `req_addr`  in  ADDRESSBITS  start address; latched on accept.
- `req_len`  in  LENBITS  number of bytes; latched on accept.
- `so`  in  1  SRAM serial data out (MISO).
- `cs`  out  1  SRAM chip select, active low.
- `sck`  out  1  SRAM serial clock, SPI mode 0.
- `si`  out  1  SRAM serial data in (MOSI).
- `data`  out  8  last received byte, MSB first on the wire.
- `data_valid`  out  1  one-cycle strobe; `data` is new this cycle.
- `busy`  out  1  high from the cycle after accept until `done`.
- `done`  out  1  one-cycle pulse at burst end.

## Operation
- All outputs are registered. Reset values: `cs`=1, `sck`=0, `si`=0, `data`=0, `data_valid`=0, `busy`=0, `done`=0. The FSM resets to IDLE.
- FSM states and transitions:
  - IDLE → OPCODE when `req` is 1 and `req_len` is nonzero.
  - OPCODE → ADDR after 8 bits.
  - ADDR → DATA after ADDRESSBITS bits.
  - DATA → GAP after `req_len`×8 bits.
  - GAP → IDLE after CS_GAP cycles.
- Accept: `req`=1 in IDLE latches the address and length. `req` seen while `busy`=1 is ignored; there is no queue.
- Zero-length request (`req_len`=0): accepted. `busy` is 1 for one cycle, then `done` pulses. `cs` never goes low.
- Bit timing: each SPI bit takes 2 cycles, phase 0 with `sck`=0, then phase 1 with `sck`=1.
  - `si` changes only when entering phase 0.
  - `so` is sampled at the edge that ends phase 1.
- Transmit data:
  - OPCODE: `si` carries OPCODE[7:0].
  - ADDR: `si` carries the address, MSB first.
  - DATA and IDLE: `si`=0.
- Receive: `so` feeds an 8-bit shift register. At the sample edge of the 8th bit of each byte, `data` loads {shift[6:0], so} and `data_valid` goes high for one cycle.
- Byte counter: loaded with `req_len`, decremented per completed byte. DATA exits when it reaches 0.
- The block never re-sends the address mid-burst. Wrap past the top of the SRAM is the memory's behaviour and is not checked here.
- End of burst: at the last sample edge, `cs`←1 and `sck`←0. After CS_GAP cycles, `done`←1 and `busy`←0 on the same edge.
- Reset mid-burst: at the next edge all outputs return to reset values, `cs`←1 and the FSM goes to IDLE. No `done` and no partial-byte `data_valid` are produced.

## Timing
- Edges are counted from the accept edge E0 (`req` sampled high in IDLE).
- At E0: `cs`←0, `sck`←0, `si`←OPCODE[7], `busy`←1.
- Bit k (counting opcode, then address, then data bits) spans E(2k) to E(2k+2). `sck` rises at E(2k+1).
- Byte n (0-based) `data_valid` is registered at E(16 + 2·ADDRESSBITS + 16·(n+1)).
  - With defaults: bytes arrive at 80, 96, 112, …
- `cs` rises at E(16 + 2·ADDRESSBITS + 16·N). `done` follows CS_GAP edges later.
- Back-to-back: a `req` high during the `done` cycle is accepted at the next edge. CS is therefore high for ≥CS_GAP+1 cycles between bursts.
- `data_valid` and `done` coincide only if CS_GAP=0, which is disallowed.

## Test plan
- Reset: hold `rst` 3 cycles with random `req`/`so` → `cs`=1, `sck`=0, `si`=0, `data`=0, strobes 0, `busy`=0.
- Single byte: `req_addr`=0x000010, `req_len`=1, SO model returns 0xA5 → `si` bits are 0x03 then 0x000010, MSB first, one bit per 2 cycles. `data`=0xA5 with `data_valid` at E80. `cs` rises at E80. `done` at E82.
- Burst: `req_len`=4, model returns 0x01, 0x80, 0xFF, 0x3C → valid strobes at E80, E96, E112, E128 with those values. Exactly 4 strobes. `cs` low continuously E0–E128.
- Handshake: `req` pulsed at E20 while busy → ignored. `req` held high through `done` → second burst accepted at the edge after `done`, with `cs` high ≥3 cycles between bursts.
- Zero length: `req_len`=0 → `busy` high 1 cycle, then `done` pulse. `cs` stays 1 and `sck` never toggles.
- Reset mid-address, with `rst` asserted at E30 → `cs`=1 and `busy`=0 at E31. No `data_valid` or `done`. A new request afterwards completes normally.
